// File: rtl/iram_loader_pkg.sv
// Shared constants and FSM encoding for the instruction RAM boot loader.
package iram_loader_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/iram_loader_if.sv
// Fetch port and byte-stream load port between the core/boot host and the loader.
interface iram_loader_if
  import iram_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]       rom_addr_i;
  logic              rom_en_i;
  logic [INST_W-1:0] inst_o;
  logic              ld_start_i;
  logic [BYTE_W-1:0] ld_byte_i;
  logic              ld_valid_i;
  logic              ld_ready_o;
  logic              ld_end_i;
  logic              ld_err_o;
  logic [AW:0]       ld_words_o;
  logic              core_rst_n_o;

  modport master (
    output rom_addr_i, rom_en_i, ld_start_i, ld_byte_i, ld_valid_i, ld_end_i,
    input  inst_o, ld_ready_o, ld_err_o, ld_words_o, core_rst_n_o
  );

  modport slave (
    input  rom_addr_i, rom_en_i, ld_start_i, ld_byte_i, ld_valid_i, ld_end_i,
    output inst_o, ld_ready_o, ld_err_o, ld_words_o, core_rst_n_o
  );

endinterface

// File: rtl/iram_loader_mem.sv
// DEPTH x 32 synchronous RAM: one write port, one registered read port that
// holds its output while the read enable is low. Read-first on collisions.
module iram_mem
  import iram_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
)(
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [INST_W-1:0]          wdata,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [INST_W-1:0]          rdata
);

  logic [INST_W-1:0] mem [DEPTH];

  // Write and registered read; nonblocking read returns pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/iram_loader.sv
// Instruction memory with boot loader: assembles a little-endian byte stream
// into words, holds the core in reset until the image is in, then serves fetches.
module iram_loader
  import iram_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
)(
  input  logic         clk,
  input  logic         rst_n,
  iram_loader_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t            state, state_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [23:0]       lanes, lanes_n;
  logic [AW-1:0]     wr_ptr, wr_ptr_n;
  logic [AW:0]       words, words_n;
  logic              err, err_n;
  logic              ready_q;
  logic              core_rst_q;
  logic              nop_q, nop_n;

  logic              we;
  logic [INST_W-1:0] wdata;
  logic              re;
  logic              oor;
  logic              full;
  logic              accept;
  logic [INST_W-1:0] rdata;
  logic              unused_addr_bits;

  // Low address bits select a byte within the word and are not used.
  assign unused_addr_bits = ^bus.rom_addr_i[1:0];

  assign oor    = |bus.rom_addr_i[31:AW+2];
  assign full   = (words == (AW+1)'(DEPTH));
  assign accept = bus.ld_valid_i && ready_q;
  assign re     = (state == RUN) && bus.rom_en_i && !oor;

  // Next-state, byte assembly, word write and fetch-select logic.
  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    lanes_n    = lanes;
    wr_ptr_n   = wr_ptr;
    words_n    = words;
    err_n      = err;
    we         = 1'b0;
    wdata      = '0;
    nop_n      = 1'b1;

    if (state == RUN) begin
      nop_n = bus.rom_en_i ? oor : nop_q;
    end

    case (state)
      IDLE: begin
        if (bus.ld_start_i) begin
          state_n = LOAD;
        end else if (bus.ld_end_i) begin
          state_n = RUN;
        end
      end
      LOAD: begin
        if (!bus.ld_start_i) begin
          if (accept) begin
            if (full) begin
              err_n = 1'b1;
            end else if (byte_idx == 2'd3) begin
              we         = 1'b1;
              wdata      = {bus.ld_byte_i, lanes};
              wr_ptr_n   = (wr_ptr == AW'(DEPTH - 1)) ? wr_ptr : wr_ptr + AW'(1);
              words_n    = words + (AW+1)'(1);
              byte_idx_n = 2'd0;
              lanes_n    = '0;
            end else begin
              case (byte_idx)
                2'd0:    lanes_n[7:0]   = bus.ld_byte_i;
                2'd1:    lanes_n[15:8]  = bus.ld_byte_i;
                default: lanes_n[23:16] = bus.ld_byte_i;
              endcase
              byte_idx_n = byte_idx + 2'd1;
            end
          end
          if (bus.ld_end_i) begin
            state_n = (byte_idx_n != 2'd0) ? FLUSH : RUN;
          end
        end
      end
      FLUSH: begin
        if (!err && (byte_idx != 2'd0)) begin
          we      = 1'b1;
          wdata   = {8'h00, lanes};
          words_n = words + (AW+1)'(1);
        end
        byte_idx_n = 2'd0;
        lanes_n    = '0;
        state_n    = RUN;
      end
      RUN: begin
        if (bus.ld_start_i) begin
          state_n = LOAD;
        end
      end
      default: state_n = IDLE;
    endcase

    // A start pulse restarts the load from any state except the one-cycle flush.
    if (bus.ld_start_i && (state != FLUSH)) begin
      state_n    = LOAD;
      byte_idx_n = 2'd0;
      lanes_n    = '0;
      wr_ptr_n   = '0;
      words_n    = '0;
      err_n      = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      lanes      <= '0;
      wr_ptr     <= '0;
      words      <= '0;
      err        <= 1'b0;
      ready_q    <= 1'b0;
      core_rst_q <= 1'b0;
      nop_q      <= 1'b1;
    end else begin
      state      <= state_n;
      byte_idx   <= byte_idx_n;
      lanes      <= lanes_n;
      wr_ptr     <= wr_ptr_n;
      words      <= words_n;
      err        <= err_n;
      ready_q    <= (state_n == LOAD) && !err_n;
      core_rst_q <= (state_n == RUN);
      nop_q      <= nop_n;
    end
  end

  iram_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (re),
    .raddr (bus.rom_addr_i[AW+1:2]),
    .rdata (rdata)
  );

  // Both selects are flops, so the fetch output is glitch-free.
  assign bus.inst_o       = nop_q ? NOP_INST : rdata;
  assign bus.ld_ready_o   = ready_q;
  assign bus.ld_err_o     = err;
  assign bus.ld_words_o   = words;
  assign bus.core_rst_n_o = core_rst_q;

endmodule

// File: tb/tb_iram_loader.sv
// Scoreboard bench for iram_loader: directed boot scenarios then random traffic,
// all checked against a byte-queue reference model of the loader.
module tb_iram_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum int {M_IDLE, M_LOAD, M_FLUSH, M_RUN} mstate_e;

  typedef struct {
    logic [31:0] inst;
    bit          inst_known;
    bit          core;
    bit          rdy;
    bit          err;
    int          words;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iram_loader_if #(.DEPTH(DEPTH)) bus ();
  iram_loader #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  // Reference model state
  mstate_e     ms;
  logic [7:0]  pend[$];
  int          mwords;
  bit          merr;
  logic [31:0] mmem [DEPTH];
  bit          mknown [DEPTH];
  logic [31:0] minst;
  bit          minst_known;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    ms = M_IDLE;
    pend.delete();
    mwords = 0;
    merr = 1'b0;
    minst = NOP;
    minst_known = 1'b1;
  endtask

  task automatic model_restart();
    pend.delete();
    mwords = 0;
    merr = 1'b0;
    ms = M_LOAD;
  endtask

  task automatic model_write(input logic [31:0] w);
    mmem[mwords] = w;
    mknown[mwords] = 1'b1;
    mwords++;
  endtask

  task automatic model_step(input bit st, input bit fin, input bit vld, input logic [7:0] b,
                            input bit fen, input logic [31:0] a);
    logic [31:0] w;
    int idx;
    // Fetch sees memory before any write of this cycle.
    if (ms == M_RUN) begin
      if (fen) begin
        if ((a >> (AW + 2)) != 0) begin
          minst = NOP;
          minst_known = 1'b1;
        end else begin
          idx = int'((a >> 2) % DEPTH);
          minst = mmem[idx];
          minst_known = mknown[idx];
        end
      end
    end else begin
      minst = NOP;
      minst_known = 1'b1;
    end
    case (ms)
      M_IDLE: begin
        if (st) model_restart();
        else if (fin) ms = M_RUN;
      end
      M_LOAD: begin
        if (st) model_restart();
        else begin
          if (vld && !merr) begin
            if (mwords == DEPTH) merr = 1'b1;
            else begin
              pend.push_back(b);
              if (pend.size() == 4) begin
                model_write({pend[3], pend[2], pend[1], pend[0]});
                pend.delete();
              end
            end
          end
          if (fin) ms = (pend.size() != 0) ? M_FLUSH : M_RUN;
        end
      end
      M_FLUSH: begin
        if (!merr && pend.size() != 0) begin
          w = '0;
          for (int i = 0; i < pend.size(); i++) w[8*i +: 8] = pend[i];
          model_write(w);
        end
        pend.delete();
        ms = M_RUN;
      end
      default: begin
        if (st) model_restart();
      end
    endcase
  endtask

  task automatic cyc(input bit rst, input bit st, input bit fin, input bit vld,
                     input logic [7:0] b, input bit fen, input logic [31:0] a);
    exp_t e;
    @(negedge clk);
    rst_n          = ~rst;
    bus.ld_start_i = st;
    bus.ld_end_i   = fin;
    bus.ld_valid_i = vld;
    bus.ld_byte_i  = b;
    bus.rom_en_i   = fen;
    bus.rom_addr_i = a;
    if (rst) model_reset();
    else model_step(st, fin, vld, b, fen, a);
    e.inst       = minst;
    e.inst_known = minst_known;
    e.core       = (ms == M_RUN);
    e.rdy        = (ms == M_LOAD) && !merr;
    e.err        = merr;
    e.words      = mwords;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00, 0, 32'h0);
  endtask

  task automatic send(input logic [7:0] b, input bit fin);
    cyc(0, 0, fin, 1, b, 0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] a, input bit en);
    cyc(0, 0, 0, 0, 8'h00, en, a);
  endtask

  task automatic start();
    cyc(0, 1, 0, 0, 8'h00, 0, 32'h0);
  endtask

  task automatic finish_load();
    cyc(0, 0, 1, 0, 8'h00, 0, 32'h0);
  endtask

  // Monitor: one expected record per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.inst_known) chk("inst_o", bus.inst_o, e.inst);
        chk("core_rst_n_o", 32'(bus.core_rst_n_o), 32'(e.core));
        chk("ld_ready_o", 32'(bus.ld_ready_o), 32'(e.rdy));
        chk("ld_err_o", 32'(bus.ld_err_o), 32'(e.err));
        chk("ld_words_o", 32'(bus.ld_words_o), 32'(e.words));
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] img1 [8];
    logic [7:0] img3 [5];
    int r;
    logic [31:0] a;
    img1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    img3 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    for (int i = 0; i < DEPTH; i++) mknown[i] = 1'b0;
    rst_n = 1'b0;
    bus.ld_start_i = 0; bus.ld_end_i = 0; bus.ld_valid_i = 0;
    bus.ld_byte_i = 0; bus.rom_en_i = 0; bus.rom_addr_i = 0;
    model_reset();

    // Reset values
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 8'h00, 0, 32'h0);
    idle(2);

    // Two-word image, then release
    start();
    for (int i = 0; i < 8; i++) send(img1[i], 0);
    finish_load();
    idle(2);

    // Fetch, hold with enable low, out-of-range fetch
    fetch(32'h4, 1);
    fetch(32'h0, 0);
    fetch(32'h8, 0);
    fetch(32'hC, 0);
    fetch(32'h1000_0000, 1);
    fetch(32'h0, 1);
    fetch(32'h7, 1);

    // Partial last word with end on the final byte
    start();
    for (int i = 0; i < 5; i++) send(img3[i], i == 4);
    idle(2);
    fetch(32'h4, 1);
    fetch(32'h0, 1);

    // Overflow: 17 bytes into a 4-word memory
    start();
    for (int i = 0; i < 17; i++) send(8'(8'h40 + i), 0);
    send(8'h99, 0);
    finish_load();
    idle(1);
    for (int i = 0; i < DEPTH; i++) fetch(32'(4 * i), 1);

    // Restart from RUN, reset mid-load, bypass release
    cyc(0, 1, 0, 0, 8'h00, 1, 32'h4);
    idle(2);
    send(8'h01, 0);
    send(8'h02, 0);
    cyc(1, 0, 0, 0, 8'h00, 0, 32'h0);
    cyc(1, 0, 0, 0, 8'h00, 0, 32'h0);
    idle(1);
    finish_load();
    for (int i = 0; i < DEPTH; i++) fetch(32'(4 * i), 1);

    // Start and end together mid-load: restart wins
    start();
    for (int i = 0; i < 6; i++) send(8'(8'hE0 + i), 0);
    cyc(0, 1, 1, 1, 8'h55, 0, 32'h0);
    idle(3);
    send(8'h77, 1);
    idle(2);
    fetch(32'h0, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 999));
      a = {28'h0, 2'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) a[31:AW+2] = 30'($urandom);
      cyc(r < 4,
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 3) != 0,
          8'($urandom),
          $urandom_range(0, 3) != 0,
          a);
    end

    idle(2);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending records", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
